// File: rtl/dmem_pkg.sv
// Shared constants, reset image and arbitration state type for the data-memory arbiter.
package dmem_pkg;

    localparam logic [31:0] BASE_ADDR = 32'd388;
    localparam int unsigned NUM_WORDS = 6;
    localparam int unsigned MAX_WAIT  = 3;

    // Reset image: every word clears except one preloaded constant.
    localparam int unsigned RST_IDX = 4;
    localparam logic [31:0] RST_VAL = 32'd5;

    // Word exported on the mem3 tap.
    localparam int unsigned TAP_IDX = 3;

    typedef enum logic {
        ARB_P = 1'b0,
        ARB_D = 1'b1
    } arb_state_e;

    function automatic logic [31:0] reset_word(input int unsigned idx);
        return (idx == RST_IDX) ? RST_VAL : 32'd0;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Register-file data bank: one write port, one registered read port, reset image, word-3 tap.
module dmem_bank #(
    parameter int unsigned NUM_WORDS = 6,
    parameter int unsigned IDX_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata,
    output logic [31:0]      mem3
);
    import dmem_pkg::*;

    logic [31:0] mem_q [NUM_WORDS];
    logic [31:0] mem_d [NUM_WORDS];
    logic [31:0] rdata_q, rdata_d;

    // Next memory image and read data; a read returns the pre-edge contents.
    always_comb begin
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[waddr] = wdata;
        end
        rdata_d = re ? mem_q[raddr] : 32'd0;
    end

    // Storage and read register with synchronous reset to the reset image.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= reset_word(i);
            end
            rdata_q <= 32'd0;
        end else begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign mem3  = mem_q[TAP_IDX];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: pipeline port P normally wins, debug port D is promoted
// to priority after MAX_WAIT consecutive denials. Decodes addresses and routes responses.
module dmem_arbiter #(
    parameter logic [31:0] BASE_ADDR = dmem_pkg::BASE_ADDR,
    parameter int unsigned NUM_WORDS = dmem_pkg::NUM_WORDS,
    parameter int unsigned MAX_WAIT  = dmem_pkg::MAX_WAIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_req,
    input  logic        p_we,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    output logic        p_gnt,
    output logic        p_rvalid,
    output logic [31:0] p_rdata,
    output logic        p_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        stall,
    output logic [31:0] mem3
);
    import dmem_pkg::*;

    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [31:0] SPAN  = 32'(4 * NUM_WORDS);

    arb_state_e state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       p_rvalid_q, p_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic       p_err_q, p_err_d, d_err_q, d_err_d;
    logic       load_ok_q, load_ok_d;

    logic [31:0]      p_off, d_off, sel_wdata, bank_rdata;
    logic             p_valid, d_valid, sel_valid, sel_we, any_gnt;
    logic [IDX_W-1:0] p_idx, d_idx, sel_idx;

    // Address decode for both ports (32-bit unsigned, word aligned, inside the window).
    always_comb begin
        p_off   = p_addr - BASE_ADDR;
        d_off   = d_addr - BASE_ADDR;
        p_valid = (p_addr[1:0] == 2'b00) && (p_addr >= BASE_ADDR) && (p_off < SPAN);
        d_valid = (d_addr[1:0] == 2'b00) && (d_addr >= BASE_ADDR) && (d_off < SPAN);
        p_idx   = p_off[IDX_W+1:2];
        d_idx   = d_off[IDX_W+1:2];
    end

    // Combinational grant; reset suppresses any access in its cycle.
    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (state_q == ARB_P) begin
                if (p_req)      p_gnt = 1'b1;
                else if (d_req) d_gnt = 1'b1;
            end else begin
                if (d_req)      d_gnt = 1'b1;
                else if (p_req) p_gnt = 1'b1;
            end
        end
        stall = p_req && !p_gnt && !reset;
    end

    // Mux the granted request onto the bank and compute next response state.
    always_comb begin
        any_gnt    = p_gnt || d_gnt;
        sel_valid  = d_gnt ? d_valid : p_valid;
        sel_we     = d_gnt ? d_we    : p_we;
        sel_idx    = d_gnt ? d_idx   : p_idx;
        sel_wdata  = d_gnt ? d_wdata : p_wdata;
        p_rvalid_d = p_gnt;
        d_rvalid_d = d_gnt;
        p_err_d    = p_gnt && !p_valid;
        d_err_d    = d_gnt && !d_valid;
        load_ok_d  = any_gnt && sel_valid && !sel_we;
    end

    // Arbitration FSM and D starvation counter (saturates at 15).
    always_comb begin
        if (d_gnt)                      wait_cnt_d = 4'd0;
        else if (d_req && wait_cnt_q != 4'hf) wait_cnt_d = wait_cnt_q + 4'd1;
        else                            wait_cnt_d = wait_cnt_q;

        state_d = state_q;
        unique case (state_q)
            ARB_P: if (d_req && !d_gnt && (32'(wait_cnt_q) + 32'd1 >= 32'(MAX_WAIT)))
                state_d = ARB_D;
            ARB_D: if (d_gnt || !d_req)
                state_d = ARB_P;
            default: state_d = ARB_P;
        endcase
    end

    // State, counter and one-cycle response registers; reset drops pending completions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_P;
            wait_cnt_q <= 4'd0;
            p_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            p_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            load_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            p_rvalid_q <= p_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            p_err_q    <= p_err_d;
            d_err_q    <= d_err_d;
            load_ok_q  <= load_ok_d;
        end
    end

    dmem_bank #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .we    (any_gnt && sel_valid && sel_we),
        .waddr (sel_idx),
        .wdata (sel_wdata),
        .re    (any_gnt && sel_valid && !sel_we),
        .raddr (sel_idx),
        .rdata (bank_rdata),
        .mem3  (mem3)
    );

    // Stores and errors return zero data; idle cycles return all zeros.
    assign p_rvalid = p_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign p_err    = p_err_q;
    assign d_err    = d_err_q;
    assign p_rdata  = (p_rvalid_q && load_ok_q) ? bank_rdata : 32'd0;
    assign d_rdata  = (d_rvalid_q && load_ok_q) ? bank_rdata : 32'd0;

endmodule
